// File: rtl/interp_pkg.sv
// Shared defaults and types for the separable 2D interpolation sequencer.
// Holds the FSM state encoding and the core latency-tracker tag.
package interp_pkg;

    localparam int X_W      = 8;
    localparam int W_W      = 10;
    localparam int N_TAP    = 8;
    localparam int CORE_LAT = 3;
    localparam int ROW_W    = 3;

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        DRAIN,
        COL,
        CWAIT,
        DONE
    } state_e;

    typedef struct packed {
        logic             vld;
        logic             is_col;
        logic [ROW_W-1:0] row;
    } tag_t;

endpackage

// File: rtl/interp_lat_tracker.sv
// Tag shift register matching the interpolator core pipeline depth.
// The exiting tag marks the cycle the core result for that issue is valid.
module interp_lat_tracker
    import interp_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t push,
    output tag_t tag_out
);

    tag_t sr_q [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            sr_q[0] <= push;
            for (int i = 1; i < LAT; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign tag_out = sr_q[LAT-1];

endmodule

// File: rtl/interp_2d_seq.sv
// 2D lookup sequencer: 8 row passes then one column pass on a shared
// 1D interpolator core, with an 8-entry buffer of row results.
module interp_2d_seq #(
    parameter int X_W      = interp_pkg::X_W,
    parameter int W_W      = interp_pkg::W_W,
    parameter int N_TAP    = interp_pkg::N_TAP,
    parameter int CORE_LAT = interp_pkg::CORE_LAT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [X_W-1:0]         i_req_x,
    input  logic [X_W-1:0]         i_req_y,
    output logic                   o_tbl_rd_en,
    output logic [2:0]             o_tbl_row,
    input  logic [N_TAP*W_W-1:0]   i_tbl_data,
    output logic                   o_core_en,
    output logic [X_W-1:0]         o_core_x,
    output logic [N_TAP*W_W-1:0]   o_core_weight,
    input  logic [W_W-1:0]         i_core_y,
    output logic                   o_res_valid,
    input  logic                   i_res_ready,
    output logic [W_W-1:0]         o_res_y,
    output logic                   o_busy
);

    import interp_pkg::*;

    localparam int WV = N_TAP * W_W;

    state_e                     state_q;
    state_e                     state_n;
    logic [X_W-1:0]             x_q;
    logic [X_W-1:0]             y_q;
    logic [2:0]                 issue_row_q;
    logic                       col_q;
    logic                       pass_q;
    logic [3:0]                 cap_cnt_q;
    logic [N_TAP-1:0][W_W-1:0]  rbuf_q;
    logic [N_TAP-1:0][W_W-1:0]  rbuf_n;
    logic [WV-1:0]              weight_q;
    tag_t                       push;
    tag_t                       tag_x;
    logic                       accept;
    logic                       row_cap;
    logic                       col_cap;
    logic                       rows_done;

    interp_lat_tracker #(
        .LAT (CORE_LAT)
    ) u_trk (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .tag_out (tag_x)
    );

    assign accept    = i_req_valid && o_req_ready;
    assign push      = {o_core_en, col_q, issue_row_q};
    assign row_cap   = tag_x.vld && !tag_x.is_col;
    assign col_cap   = tag_x.vld && tag_x.is_col;
    assign rows_done = row_cap && (cap_cnt_q == 4'(N_TAP - 1));

    // Table data arrives one cycle after the read, so row passes forward it directly
    assign o_core_weight = pass_q ? i_tbl_data : weight_q;

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_n = ROW;
            ROW:     if (o_tbl_row == 3'(N_TAP - 1)) state_n = DRAIN;
            DRAIN:   if (rows_done) state_n = COL;
            COL:     state_n = CWAIT;
            CWAIT:   if (col_cap) state_n = DONE;
            DONE:    if (i_res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        rbuf_n = rbuf_q;
        if (row_cap) begin
            rbuf_n[tag_x.row] = i_core_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            o_req_ready <= 1'b1;
            o_busy      <= 1'b0;
            o_tbl_rd_en <= 1'b0;
            o_tbl_row   <= '0;
            o_core_en   <= 1'b0;
            o_core_x    <= '0;
            o_res_valid <= 1'b0;
            o_res_y     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            issue_row_q <= '0;
            col_q       <= 1'b0;
            pass_q      <= 1'b0;
            cap_cnt_q   <= '0;
            rbuf_q      <= '0;
            weight_q    <= '0;
        end else begin
            state_q     <= state_n;
            o_req_ready <= (state_n == IDLE);
            o_busy      <= (state_n != IDLE);
            o_tbl_rd_en <= (state_n == ROW);
            o_res_valid <= (state_n == DONE);
            if (state_n == ROW) begin
                o_tbl_row <= (state_q == ROW) ? o_tbl_row + 3'd1 : 3'd0;
            end
            if (accept) begin
                x_q       <= i_req_x;
                y_q       <= i_req_y;
                cap_cnt_q <= '0;
            end else if (row_cap) begin
                cap_cnt_q <= cap_cnt_q + 4'd1;
            end
            o_core_en   <= o_tbl_rd_en || (state_n == COL);
            col_q       <= (state_n == COL);
            pass_q      <= o_tbl_rd_en;
            issue_row_q <= o_tbl_row;
            rbuf_q      <= rbuf_n;
            if (o_tbl_rd_en) begin
                o_core_x <= x_q;
            end else if (state_n == COL) begin
                o_core_x <= y_q;
            end
            // Column weights include the row result landing this same cycle
            if (pass_q) begin
                weight_q <= i_tbl_data;
            end else if (state_n == COL) begin
                weight_q <= rbuf_n;
            end
            if (col_cap) begin
                o_res_y <= i_core_y;
            end
        end
    end

endmodule

// File: tb/tb_interp_2d_seq.sv
// Bench for interp_2d_seq: builds with CORE_LAT 3, 1 and 6 share one
// coefficient table and a behavioural core that picks weight[x[7:5]].
`timescale 1ns/1ps
module tb_interp_2d_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    int         sel;
    logic       req_valid;
    logic       res_ready;
    logic [7:0] req_x;
    logic [7:0] req_y;
    logic [9:0] tbl [8][8];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 3 : (g == 1) ? 1 : 6;
        logic        rv;
        logic        rq_rdy;
        logic        rd_en;
        logic [2:0]  row;
        logic [79:0] tdata;
        logic        ce;
        logic [7:0]  cx;
        logic [79:0] cw;
        logic [9:0]  cy;
        logic        res_v;
        logic        res_rdy;
        logic [9:0]  res_y;
        logic        busy;
        logic [9:0]  pipe [LAT];

        assign rv      = req_valid && (sel == g);
        assign res_rdy = res_ready && (sel == g);
        assign cy      = pipe[LAT-1];

        interp_2d_seq #(
            .CORE_LAT (LAT)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_req_valid   (rv),
            .o_req_ready   (rq_rdy),
            .i_req_x       (req_x),
            .i_req_y       (req_y),
            .o_tbl_rd_en   (rd_en),
            .o_tbl_row     (row),
            .i_tbl_data    (tdata),
            .o_core_en     (ce),
            .o_core_x      (cx),
            .o_core_weight (cw),
            .i_core_y      (cy),
            .o_res_valid   (res_v),
            .i_res_ready   (res_rdy),
            .o_res_y       (res_y),
            .o_busy        (busy)
        );

        always @(posedge clk) begin
            if (rd_en) begin
                for (int t = 0; t < 8; t++) tdata[t*10 +: 10] <= tbl[row][t];
            end
            pipe[0] <= ce ? cw[int'(cx[7:5])*10 +: 10] : 10'h155;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    logic       m_rdy, m_rd, m_ce, m_rv, m_busy;
    logic [2:0] m_row;
    logic [7:0] m_cx;
    logic [9:0] m_ry;

    always_comb begin
        m_rdy = g_dut[0].rq_rdy; m_rd = g_dut[0].rd_en; m_ce = g_dut[0].ce;
        m_rv = g_dut[0].res_v; m_busy = g_dut[0].busy; m_row = g_dut[0].row;
        m_cx = g_dut[0].cx; m_ry = g_dut[0].res_y;
        if (sel == 1) begin
            m_rdy = g_dut[1].rq_rdy; m_rd = g_dut[1].rd_en; m_ce = g_dut[1].ce;
            m_rv = g_dut[1].res_v; m_busy = g_dut[1].busy; m_row = g_dut[1].row;
            m_cx = g_dut[1].cx; m_ry = g_dut[1].res_y;
        end else if (sel == 2) begin
            m_rdy = g_dut[2].rq_rdy; m_rd = g_dut[2].rd_en; m_ce = g_dut[2].ce;
            m_rv = g_dut[2].res_v; m_busy = g_dut[2].busy; m_row = g_dut[2].row;
            m_cx = g_dut[2].cx; m_ry = g_dut[2].res_y;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int lat_of(input int s);
        return (s == 0) ? 3 : (s == 1) ? 1 : 6;
    endfunction

    // Separable lookup: row r sampled at x, then the row results sampled at y
    function automatic logic [9:0] ref_y(input logic [7:0] x, input logic [7:0] y);
        logic [9:0] rows [8];
        for (int r = 0; r < 8; r++) rows[r] = tbl[r][x[7:5]];
        return rows[y[7:5]];
    endfunction

    task automatic tbl_formula();
        for (int r = 0; r < 8; r++)
            for (int t = 0; t < 8; t++) tbl[r][t] = 10'(16 * r + t);
    endtask

    task automatic tbl_fill(input logic [9:0] v);
        for (int r = 0; r < 8; r++)
            for (int t = 0; t < 8; t++) tbl[r][t] = v;
    endtask

    task automatic tbl_random();
        for (int r = 0; r < 8; r++)
            for (int t = 0; t < 8; t++) tbl[r][t] = 10'($urandom);
    endtask

    // Called just after a falling edge; returns just after the falling edge
    // that follows the result handshake.
    task automatic run_req(input string nm, input logic [7:0] x, input logic [7:0] y,
                           input logic [9:0] exp, input int hold, input bit keep,
                           output int acc_wait);
        int lat, t, serr, fk, herr;
        bit e_rd, e_ce;
        lat = lat_of(sel);
        req_valid = 1'b1;
        req_x = x;
        req_y = y;
        res_ready = 1'b0;
        t = 0;
        while (!m_rdy && t < 100) begin
            @(negedge clk);
            t++;
        end
        acc_wait = t;
        chk($sformatf("%s accept", nm), 32'(m_rdy), 1);
        serr = 0;
        fk = 0;
        for (int k = 1; k <= 11 + 2 * lat; k++) begin
            @(negedge clk);
            if (k == 1 && !keep) req_valid = 1'b0;
            e_rd = (k <= 8);
            e_ce = (k >= 2 && k <= 9) || (k == 10 + lat);
            if (m_rd !== e_rd || (e_rd && m_row !== 3'(k - 1)) || m_ce !== e_ce
                || (e_ce && m_cx !== ((k == 10 + lat) ? y : x))
                || m_rdy !== 1'b0 || m_busy !== 1'b1
                || m_rv !== (k == 11 + 2 * lat)) begin
                if (serr == 0) fk = k;
                serr++;
            end
        end
        chk($sformatf("%s sequence (first bad cycle %0d)", nm, fk), serr, 0);
        chk($sformatf("%s result", nm), m_ry, exp);
        if (hold > 0) begin
            herr = 0;
            for (int h = 0; h < hold; h++) begin
                if (!keep) begin
                    req_valid = 1'b1;
                    req_x = 8'($urandom);
                end
                @(negedge clk);
                if (!m_rv || m_ry !== exp || m_rdy || !m_busy) herr++;
            end
            if (!keep) begin
                req_valid = 1'b0;
                req_x = x;
            end
            chk($sformatf("%s hold stable", nm), herr, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk($sformatf("%s valid drops", nm), 32'(m_rv), 0);
        chk($sformatf("%s ready after handshake", nm), 32'(m_rdy), 1);
    endtask

    typedef struct {
        string      nm;
        int         inst;
        logic [7:0] x;
        logic [7:0] y;
        int         hold;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int  w;
        int  t;
        bit  seen;
        logic [7:0] rx, ry;

        vecs[0] = '{"lat3_basic",  0,  24, 200, 0,  96};
        vecs[1] = '{"lat3_hold5",  0,  24, 200, 5,  96};
        vecs[2] = '{"lat1_basic",  1,  24, 200, 0,  96};
        vecs[3] = '{"lat6_basic",  2,  24, 200, 0,  96};
        vecs[4] = '{"tap7_row0",   0, 255,   0, 0,   7};
        vecs[5] = '{"mid",         0, 100,  50, 1,  19};
        vecs[6] = '{"corner_lat6", 2, 224, 255, 0, 119};
        vecs[7] = '{"edge_lat1",   1,  31,  32, 2,  16};

        rst_n = 1'b0;
        sel = 0;
        req_valid = 1'b0;
        res_ready = 1'b0;
        req_x = '0;
        req_y = '0;
        tbl_formula();
        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(m_rdy), 1);
        chk("reset busy", 32'(m_busy), 0);
        chk("reset tbl_rd_en", 32'(m_rd), 0);
        chk("reset core_en", 32'(m_ce), 0);
        chk("reset res_valid", 32'(m_rv), 0);
        chk("reset res_y", m_ry, 0);
        chk("reset core_weight zero", 32'(g_dut[0].cw == '0), 1);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            sel = vecs[i].inst;
            run_req(vecs[i].nm, vecs[i].x, vecs[i].y, vecs[i].exp, vecs[i].hold, 1'b0, w);
        end

        sel = 0;
        run_req("A_held_valid", 24, 200, 96, 0, 1'b1, w);
        run_req("B_held_valid", 255, 0, 7, 0, 1'b0, w);
        chk("B accepted cycle after handshake", w, 0);

        sel = 0;
        req_valid = 1'b1;
        req_x = 24;
        req_y = 200;
        t = 0;
        while (!m_rdy && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort req_ready", 32'(m_rdy), 1);
        chk("abort busy", 32'(m_busy), 0);
        chk("abort tbl_rd_en", 32'(m_rd), 0);
        chk("abort core_en", 32'(m_ce), 0);
        chk("abort core_x", m_cx, 0);
        chk("abort core_weight zero", 32'(g_dut[0].cw == '0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (m_rv || m_busy || !m_rdy) seen = 1'b1;
        end
        chk("abort no result", 32'(seen), 0);
        run_req("after_abort", 100, 50, 19, 0, 1'b0, w);

        tbl_fill(10'd1023);
        sel = 0;
        run_req("max_weight_lat3", 0, 0, 10'd1023, 0, 1'b0, w);
        sel = 1;
        run_req("max_weight_lat1", 0, 0, 10'd1023, 0, 1'b0, w);

        for (int i = 0; i < 12; i++) begin
            sel = $urandom_range(0, 2);
            tbl_random();
            rx = 8'($urandom);
            ry = 8'($urandom);
            run_req($sformatf("rand%0d", i), rx, ry, ref_y(rx, ry),
                    $urandom_range(0, 3), 1'b0, w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
